// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle control FSM for the 8-bit CPU datapath.
//
// Each instruction is sequenced through FETCH, DECODE and then, depending on
// the opcode, EXEC, WB or JUMP before returning to FETCH. HALT is terminal
// until reset.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high
//   op[3:0]      opcode from the instruction register (instr[15:12])
//   z            zero-flag flip-flop output
//   mem_ack      instruction-memory read complete (only used in FETCH)
//   mem_req      instruction-memory read request
//   ir_load      instruction-register load strobe (combinational on mem_ack)
//   pc_en        PC register enable
//   pc_sel[1:0]  next-PC select: 00 = PC+1, 01 = absolute target
//   we3          register-file write enable
//   wd_sel[1:0]  write-data select: 00 = ALU, 01 = immediate, 10 = input port
//   alu_op[2:0]  ALU operation
//   z_load       zero-flag flip-flop load
//   halted       high in HALT
//   state[2:0]   current state code (debug)
//   instr_count  retired-instruction counter, wraps
module mc_control_unit #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           op,
  input  logic                 z,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 ir_load,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic                 we3,
  output logic [1:0]           wd_sel,
  output logic [2:0]           alu_op,
  output logic                 z_load,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StWb     = 3'd3,
    StJump   = 3'd4,
    StHalt   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 retire;
  logic [CNT_WIDTH-1:0] count_q;

  // Opcode classes
  logic is_alu, is_li, is_in, is_j, is_jz, is_jnz, is_halt;

  assign is_alu  = (op[3] == 1'b0) && (op != 4'b0000);
  assign is_li   = (op == 4'b1000);
  assign is_in   = (op == 4'b1001);
  assign is_j    = (op == 4'b1010);
  assign is_jz   = (op == 4'b1011);
  assign is_jnz  = (op == 4'b1100);
  assign is_halt = (op == 4'b1111);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    mem_req = 1'b0;
    ir_load = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = 2'b00;
    we3     = 1'b0;
    wd_sel  = 2'b00;
    alu_op  = 3'b000;
    z_load  = 1'b0;
    halted  = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        // An acknowledge arriving while reset is held must not load the IR.
        if (mem_ack && !reset) begin
          ir_load = 1'b1;
          state_d = StDecode;
        end
      end

      StDecode: begin
        pc_en  = 1'b1;
        pc_sel = 2'b00;
        if (is_alu) begin
          state_d = StExec;
        end else if (is_li || is_in) begin
          state_d = StWb;
        end else if (is_j || is_jz || is_jnz) begin
          state_d = StJump;
        end else if (is_halt) begin
          state_d = StHalt;
          retire  = 1'b1;
        end else begin
          // NOP and the unused opcodes retire straight from DECODE.
          state_d = StFetch;
          retire  = 1'b1;
        end
      end

      StExec: begin
        alu_op  = op[2:0];
        z_load  = 1'b1;
        state_d = StWb;
      end

      StWb: begin
        we3 = 1'b1;
        if (is_li) begin
          wd_sel = 2'b01;
        end else if (is_in) begin
          wd_sel = 2'b10;
        end else begin
          wd_sel = 2'b00;
          alu_op = op[2:0];
        end
        state_d = StFetch;
        retire  = 1'b1;
      end

      StJump: begin
        pc_sel = 2'b01;
        if (is_j) begin
          pc_en = 1'b1;
        end else if (is_jz) begin
          pc_en = z;
        end else if (is_jnz) begin
          pc_en = ~z;
        end
        state_d = StFetch;
        retire  = 1'b1;
      end

      StHalt: begin
        halted  = 1'b1;
        state_d = StHalt;
      end

      default: begin
        // Illegal codes 6 and 7 recover to FETCH without retiring.
        state_d = StFetch;
      end
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: random opcode stream, random
// memory latency, random zero flag and occasional resets, compared each cycle
// against an instruction-level timing model.
module tb_mc_control_unit;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    op;
  logic          z;
  logic          mem_ack;
  logic          mem_req;
  logic          ir_load;
  logic          pc_en;
  logic [1:0]    pc_sel;
  logic          we3;
  logic [1:0]    wd_sel;
  logic [2:0]    alu_op;
  logic          z_load;
  logic          halted;
  logic [2:0]    state;
  logic [CW-1:0] instr_count;

  always #5 clk = ~clk;

  mc_control_unit #(
    .CNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .z          (z),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .ir_load    (ir_load),
    .pc_en      (pc_en),
    .pc_sel     (pc_sel),
    .we3        (we3),
    .wd_sel     (wd_sel),
    .alu_op     (alu_op),
    .z_load     (z_load),
    .halted     (halted),
    .state      (state),
    .instr_count(instr_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Instruction-level model
  bit       m_fetch;
  bit       m_halted;
  int       m_k;          // cycles spent since FETCH completed
  int       m_count;
  int       halt_cycles;
  logic [3:0] cur_op;
  logic [3:0] next_op;
  bit       load_pend;

  // Cycles after FETCH, from the CPI table.
  function automatic int post_fetch_len(input logic [3:0] o);
    if (o >= 4'd1 && o <= 4'd7) return 3;
    if (o == 4'd8 || o == 4'd9) return 2;
    if (o >= 4'd10 && o <= 4'd12) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] pick_op();
    logic [3:0] o;
    o = 4'($urandom_range(0, 15));
    if (o == 4'd15 && $urandom_range(0, 3) != 0) o = 4'd11;
    return o;
  endfunction

  task automatic check_outputs();
    int e_state, e_mreq, e_irl, e_pcen, e_pcsel, e_we, e_wd, e_alu, e_zl, e_halt;
    e_state = 0; e_mreq = 0; e_irl = 0; e_pcen = 0; e_pcsel = 0;
    e_we = 0; e_wd = 0; e_alu = 0; e_zl = 0; e_halt = 0;
    if (m_halted) begin
      e_state = 5;
      e_halt  = 1;
    end else if (m_fetch) begin
      e_state = 0;
      e_mreq  = 1;
      e_irl   = int'(mem_ack);
    end else if (m_k == 0) begin
      e_state = 1;
      e_pcen  = 1;
    end else if (cur_op >= 4'd1 && cur_op <= 4'd7) begin
      e_alu = int'(cur_op) % 8;
      if (m_k == 1) begin
        e_state = 2;
        e_zl    = 1;
      end else begin
        e_state = 3;
        e_we    = 1;
      end
    end else if (cur_op == 4'd8 || cur_op == 4'd9) begin
      e_state = 3;
      e_we    = 1;
      e_wd    = (cur_op == 4'd8) ? 1 : 2;
    end else begin
      e_state = 4;
      e_pcsel = 1;
      if (cur_op == 4'd10)      e_pcen = 1;
      else if (cur_op == 4'd11) e_pcen = int'(z);
      else                      e_pcen = int'(!z);
    end
    check("state",       state,       e_state);
    check("mem_req",     mem_req,     e_mreq);
    check("ir_load",     ir_load,     e_irl);
    check("pc_en",       pc_en,       e_pcen);
    check("pc_sel",      pc_sel,      e_pcsel);
    check("we3",         we3,         e_we);
    check("wd_sel",      wd_sel,      e_wd);
    check("alu_op",      alu_op,      e_alu);
    check("z_load",      z_load,      e_zl);
    check("halted",      halted,      e_halt);
    check("instr_count", instr_count, m_count);
  endtask

  task automatic model_reset();
    m_fetch     = 1'b1;
    m_halted    = 1'b0;
    m_k         = 0;
    m_count     = 0;
    halt_cycles = 0;
    load_pend   = 1'b0;
  endtask

  initial begin
    bit do_reset;
    reset   = 1'b1;
    op      = 4'd0;
    cur_op  = 4'd0;
    z       = 1'b0;
    mem_ack = 1'b1;
    model_reset();

    @(negedge clk);
    #1;
    check("rst_state",   state,       0);
    check("rst_mem_req", mem_req,     1);
    check("rst_ir_load", ir_load,     0);
    check("rst_count",   instr_count, 0);

    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      reset = 1'b0;
      if (load_pend) begin
        op        = next_op;
        cur_op    = next_op;
        load_pend = 1'b0;
      end
      do_reset = (m_halted && halt_cycles >= 20) || ($urandom_range(0, 79) == 0);
      if (do_reset) begin
        reset   = 1'b1;
        mem_ack = 1'(($urandom_range(0, 1)));
        #1;
        check("async_state",   state,       0);
        check("async_z_load",  z_load,      0);
        check("async_count",   instr_count, 0);
        check("async_mem_req", mem_req,     1);
        check("async_ir_load", ir_load,     0);
        check("async_halted",  halted,      0);
        model_reset();
        continue;
      end
      mem_ack = ($urandom_range(0, 2) != 0);
      z       = 1'(($urandom_range(0, 1)));
      #1;
      check_outputs();
      if (m_halted) begin
        halt_cycles++;
      end else if (m_fetch) begin
        if (mem_ack) begin
          m_fetch   = 1'b0;
          m_k       = 0;
          load_pend = 1'b1;
          next_op   = pick_op();
        end
      end else begin
        m_k++;
        if (m_k == post_fetch_len(cur_op)) begin
          m_count = (m_count + 1) % (1 << CW);
          if (cur_op == 4'd15) m_halted = 1'b1;
          else                 m_fetch  = 1'b1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
